// File: rtl/mic_volume_level.sv
// Windowed peak detector for the sound bar: tracks the max mic sample per window,
// then publishes a 0..16 level (binary and thermometer) with one-step-per-window decay.
module mic_volume_level #(
   parameter int WINDOW     = 4000,
   parameter int BASELINE   = 2048,
   parameter int STEP_SHIFT = 7,
   parameter int DECAY_EN   = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        sample_valid,
   input  logic [11:0] mic_in,
   output logic [15:0] level,
   output logic [4:0]  level_num,
   output logic [11:0] peak,
   output logic        level_valid
);

   localparam int DATA_W = 12;
   localparam int CNT_W  = $clog2(WINDOW + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW - 1);
   localparam logic [DATA_W-1:0] BASE     = DATA_W'(BASELINE);

   // Map a peak to a bar level; anything at or below the DC midpoint is silence.
   function automatic logic [4:0] level_target(input logic [DATA_W-1:0] pk);
      logic [DATA_W-1:0] excess;
      logic [DATA_W-1:0] steps;
      excess = (pk > BASE) ? pk - BASE : '0;
      steps  = excess >> STEP_SHIFT;
      if (excess == '0)
         return 5'd0;
      else if (steps >= DATA_W'(15))
         return 5'd16;
      else
         return 5'(steps) + 5'd1;
   endfunction

   function automatic logic [15:0] thermo(input logic [4:0] n);
      logic [16:0] t;
      t = (17'd1 << n) - 17'd1;
      return t[15:0];
   endfunction

   logic [CNT_W-1:0]  cnt_p0;
   logic [DATA_W-1:0] run_max_p0;
   logic [DATA_W-1:0] peak_p0;
   logic              vld_p0;
   logic [DATA_W-1:0] sample_max;
   logic [4:0]        target;
   logic [4:0]        next_num;

   always_comb begin
      sample_max = (mic_in > run_max_p0) ? mic_in : run_max_p0;
      target     = level_target(peak_p0);
      next_num   = target;
      if (target < level_num && DECAY_EN != 0)
         next_num = level_num - 5'd1;
   end

   // Stage p0: accumulate the running max; the closing sample folds into the captured peak
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_p0     <= '0;
         run_max_p0 <= '0;
         peak_p0    <= '0;
         vld_p0     <= 1'b0;
      end else begin
         vld_p0 <= 1'b0;
         if (sample_valid) begin
            if (cnt_p0 == CNT_LAST) begin
               cnt_p0     <= '0;
               run_max_p0 <= '0;
               peak_p0    <= sample_max;
               vld_p0     <= 1'b1;
            end else begin
               cnt_p0     <= cnt_p0 + CNT_W'(1);
               run_max_p0 <= sample_max;
            end
         end
      end
   end

   // Stage p1: level update, all outputs change together with the valid pulse
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level       <= '0;
         level_num   <= '0;
         peak        <= '0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= vld_p0;
         if (vld_p0) begin
            level_num <= next_num;
            level     <= thermo(next_num);
            peak      <= peak_p0;
         end
      end
   end

endmodule

// File: tb/tb_mic_volume_level.sv
// Directed bench for mic_volume_level: WINDOW=4 with and without decay, plus WINDOW=1.
module tb_mic_volume_level;

   logic        clock;
   logic        reset_n;
   logic        sample_valid;
   logic [11:0] mic_in;

   logic [15:0] level,    nd_level,    w1_level;
   logic [4:0]  lnum,     nd_lnum,     w1_lnum;
   logic [11:0] peak,     nd_peak,     w1_peak;
   logic        lv,       nd_lv,       w1_lv;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   mic_volume_level #(.WINDOW(4), .BASELINE(2048), .STEP_SHIFT(7), .DECAY_EN(1)) dut (
      .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .mic_in(mic_in),
      .level(level), .level_num(lnum), .peak(peak), .level_valid(lv));

   mic_volume_level #(.WINDOW(4), .BASELINE(2048), .STEP_SHIFT(7), .DECAY_EN(0)) dut_nd (
      .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .mic_in(mic_in),
      .level(nd_level), .level_num(nd_lnum), .peak(nd_peak), .level_valid(nd_lv));

   mic_volume_level #(.WINDOW(1), .BASELINE(2048), .STEP_SHIFT(7), .DECAY_EN(1)) dut_w1 (
      .clock(clock), .reset_n(reset_n), .sample_valid(sample_valid), .mic_in(mic_in),
      .level(w1_level), .level_num(w1_lnum), .peak(w1_peak), .level_valid(w1_lv));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) if (lv === 1'b1) pulses++;

   task automatic send(input logic [11:0] v);
      sample_valid = 1'b1;
      mic_in       = v;
      @(posedge clock); #1;
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      sample_valid = 1'b0;
      reset_n      = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      sample_valid = 1'b0;
      mic_in       = 12'd0;
      reset_n      = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (level !== 16'h0000 || lnum !== 5'd0 || peak !== 12'd0 || lv !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got level=%h num=%0d peak=%0d vld=%b want 0000/0/0/0", level, lnum, peak, lv);
      end
      reset_n = 1'b1;
      send(12'd4000);
      send(12'd4000);
      @(posedge clock); #1;
      checks++;
      if (w1_lnum !== 5'd16) begin
         errors++;
         $display("FAIL w1_before_reset: got %0d want 16", w1_lnum);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (level !== 16'h0000 || lnum !== 5'd0 || peak !== 12'd0 || w1_lnum !== 5'd0 || w1_peak !== 12'd0) begin
         errors++;
         $display("FAIL reset_midwindow: got level=%h num=%0d peak=%0d w1num=%0d want 0000/0/0/0", level, lnum, peak, w1_lnum);
      end
      @(negedge clock);
      reset_n = 1'b1;
      pulses  = 0;
      @(posedge clock); #1;
      repeat (4) send(12'd2048);
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b1 || level !== 16'h0000 || lnum !== 5'd0 || peak !== 12'd2048) begin
         errors++;
         $display("FAIL reset_window: got vld=%b level=%h num=%0d peak=%0d want 1/0000/0/2048", lv, level, lnum, peak);
      end
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b0 || pulses != 1) begin
         errors++;
         $display("FAIL reset_pulse_count: got vld=%b pulses=%0d want 0/1", lv, pulses);
      end
   endtask

   task automatic test_rise();
      send(12'd2100);
      send(12'd3000);
      send(12'd2200);
      send(12'd2050);
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b1 || peak !== 12'd3000 || lnum !== 5'd8 || level !== 16'h00FF) begin
         errors++;
         $display("FAIL rise: got vld=%b peak=%0d num=%0d level=%h want 1/3000/8/00ff", lv, peak, lnum, level);
      end
      checks++;
      if (nd_lnum !== 5'd8 || nd_level !== 16'h00FF) begin
         errors++;
         $display("FAIL rise_nodecay: got num=%0d level=%h want 8/00ff", nd_lnum, nd_level);
      end
      checks++;
      if (w1_lnum !== 5'd6 || w1_peak !== 12'd2050 || w1_level !== 16'h003F) begin
         errors++;
         $display("FAIL window1: got num=%0d peak=%0d level=%h want 6/2050/003f", w1_lnum, w1_peak, w1_level);
      end
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b0 || lnum !== 5'd8) begin
         errors++;
         $display("FAIL rise_single_pulse: got vld=%b num=%0d want 0/8", lv, lnum);
      end
   endtask

   task automatic test_saturation();
      send(12'd2048);
      send(12'd4095);
      send(12'd2000);
      send(12'd2100);
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b1 || lnum !== 5'd16 || level !== 16'hFFFF || peak !== 12'd4095 || nd_lnum !== 5'd16) begin
         errors++;
         $display("FAIL saturation: got vld=%b num=%0d level=%h peak=%0d ndnum=%0d want 1/16/ffff/4095/16", lv, lnum, level, peak, nd_lnum);
      end
   endtask

   task automatic test_decay();
      logic [4:0]  exp_num [3];
      logic [15:0] exp_lvl [3];
      exp_num = '{5'd7, 5'd6, 5'd5};
      exp_lvl = '{16'h007F, 16'h003F, 16'h001F};
      do_reset();
      send(12'd2100);
      send(12'd3000);
      send(12'd2200);
      send(12'd2050);
      @(posedge clock); #1;
      checks++;
      if (lnum !== 5'd8) begin
         errors++;
         $display("FAIL decay_start: got %0d want 8", lnum);
      end
      for (int w = 0; w < 3; w++) begin
         repeat (4) send(12'd2048);
         @(posedge clock); #1;
         checks++;
         if (lv !== 1'b1 || lnum !== exp_num[w] || level !== exp_lvl[w]) begin
            errors++;
            $display("FAIL decay_step%0d: got vld=%b num=%0d level=%h want 1/%0d/%h", w, lv, lnum, level, exp_num[w], exp_lvl[w]);
         end
         checks++;
         if (nd_lnum !== 5'd0 || nd_level !== 16'h0000) begin
            errors++;
            $display("FAIL nodecay_step%0d: got num=%0d level=%h want 0/0000", w, nd_lnum, nd_level);
         end
      end
   endtask

   task automatic test_gaps();
      logic [11:0] a [4];
      logic [11:0] b [4];
      a = '{12'd2100, 12'd2500, 12'd3000, 12'd3500};
      b = '{12'd2000, 12'd2000, 12'd2010, 12'd2040};
      @(posedge clock); #1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         send(a[i]);
         if (i < 3) repeat ($urandom_range(1, 3)) @(posedge clock);
         #1;
      end
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b1 || peak !== 12'd3500 || lnum !== 5'd12 || level !== 16'h0FFF) begin
         errors++;
         $display("FAIL gaps_window: got vld=%b peak=%0d num=%0d level=%h want 1/3500/12/0fff", lv, peak, lnum, level);
      end
      for (int i = 0; i < 4; i++) begin
         send(b[i]);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (peak !== 12'd2040 || lnum !== 5'd11 || nd_lnum !== 5'd0 || pulses != 2) begin
         errors++;
         $display("FAIL gaps_next_window: got peak=%0d num=%0d ndnum=%0d pulses=%0d want 2040/11/0/2", peak, lnum, nd_lnum, pulses);
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] v [12];
      logic [4:0]  exp_num [3];
      logic [4:0]  exp_nd  [3];
      logic [11:0] exp_pk  [3];
      v = '{12'd2200, 12'd2300, 12'd2400, 12'd2500,
            12'd4095, 12'd2048, 12'd2048, 12'd2048,
            12'd2100, 12'd2100, 12'd2100, 12'd2300};
      exp_num = '{5'd4, 5'd16, 5'd15};
      exp_nd  = '{5'd4, 5'd16, 5'd2};
      exp_pk  = '{12'd2500, 12'd4095, 12'd2300};
      do_reset();
      for (int i = 0; i <= 12; i++) begin
         sample_valid = (i < 12);
         mic_in       = (i < 12) ? v[i] : 12'd0;
         @(posedge clock); #1;
         if (i >= 4 && i % 4 == 0) begin
            checks++;
            if (lv !== 1'b1 || lnum !== exp_num[i/4-1] || peak !== exp_pk[i/4-1] || nd_lnum !== exp_nd[i/4-1]) begin
               errors++;
               $display("FAIL b2b_win%0d: got vld=%b num=%0d peak=%0d ndnum=%0d want 1/%0d/%0d/%0d",
                        i/4, lv, lnum, peak, nd_lnum, exp_num[i/4-1], exp_pk[i/4-1], exp_nd[i/4-1]);
            end
         end else begin
            checks++;
            if (lv !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle_cycle%0d: got vld=%b want 0", i, lv);
            end
         end
      end
      sample_valid = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (lv !== 1'b0) begin
         errors++;
         $display("FAIL b2b_tail: got vld=%b want 0", lv);
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_saturation();
      test_decay();
      test_gaps();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mic_volume_level.md
Name: mic_volume_level

Overview:
- Upstream stage of the on-screen sound bar renderer.
- Consumes 12-bit microphone samples and tracks the peak amplitude over a fixed window of samples.
- At each window end, converts the peak to a 0..16 level and publishes it as the 16-bit thermometer code the sound bar uses as `tester`, plus the binary level.
- Displayed level rises instantly and falls at most one step per window (decay), giving a steady bar.

Parameters:
- WINDOW, 4000, samples per measurement window (≥1); 4000 samples at 20 kHz = 0.2 s.
- BASELINE, 2048, mic DC midpoint; samples at or below it count as silence.
- STEP_SHIFT, 7, right-shift applied to excess amplitude; each level spans 2^STEP_SHIFT codes.
- DECAY_EN, 1, 1 = falling level drops one step per window; 0 = level jumps directly to the new value.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe, mic_in valid this cycle
- mic_in  in  12  unsigned mic sample
- level  out  16  thermometer code, (1<<level_num)-1; 16 = 16'hFFFF
- level_num  out  5  current displayed level 0..16
- peak  out  12  peak of the last completed window
- level_valid  out  1  one-cycle pulse when level/level_num/peak update

Behaviour:
- Reset (async assert, sync release): level=0, level_num=0, peak=0, level_valid=0, sample counter=0, running max=0.
- Sample accumulation: on a clock edge with sample_valid=1, running max <= max(running max, mic_in), and the counter increments.
- Window close: when the counter equals WINDOW-1 and sample_valid=1:
  - the current sample is included in the peak: peak <= max(running max, mic_in);
  - the counter returns to 0;
  - the running max clears to 0, so the next window starts fresh;
  - no sample is lost or double-counted.
- Level computation (registered, one cycle after window close):
  - excess = peak > BASELINE ? peak - BASELINE : 0, 12-bit;
  - target = excess==0 ? 0 : min(16, (excess >> STEP_SHIFT) + 1).
  - Default parameters: 2049..2175 → 1; 4095 → 16; ≤2048 → 0.
- Update rule:
  - target ≥ level_num → level_num <= target;
  - otherwise DECAY_EN=1 → level_num <= level_num - 1, DECAY_EN=0 → level_num <= target.
- Thermometer output: level is derived from the registered level_num in the same update cycle, so level and level_num always agree.
- level_valid:
  - asserts exactly on the cycle level/level_num change registers, i.e. 1 cycle after the closing sample edge (total latency 2 clocks from the closing sample_valid);
  - pulses even when the value is unchanged.
- Idle: sample_valid=0 → nothing changes; the window advances only on valid samples, never on clock cycles.
- Back-to-back valids (every cycle): supported; the window-close pipeline is one stage deep, and a closing sample followed immediately by a new window's first sample is handled correctly.
- WINDOW=1: every valid sample closes a window; peak = that sample.
- Reset mid-window: all state clears; the partial window is discarded and the next window starts at the first valid after reset_n rises.
- Widths:
  - counter is $clog2(WINDOW+1) bits;
  - all comparisons are unsigned;
  - target is saturated at 16 before use.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset_n=0 mid-window with WINDOW=4 after 2 samples of 4000 → outputs 0; after release, 4 samples of 2048 → level_valid pulses once, level=16'h0000, level_num=0, peak=2048.
- Rise: WINDOW=4, samples 2100,3000,2200,2050 → 2 clocks after the 4th valid, peak=3000, level_num=8 (952>>7=7,+1), level=16'h00FF, level_valid=1 for exactly one cycle.
- Saturation: WINDOW=4, one sample 4095 in window → level_num=16, level=16'hFFFF.
- Decay (DECAY_EN=1): from level_num=8, three windows of all-2048 → level_num 7, 6, 5 (level 16'h007F, 16'h003F, 16'h001F); DECAY_EN=0 → drops straight to 0 / 16'h0000.
- Window boundary + gaps: WINDOW=4, sample_valid asserted on non-consecutive cycles with random idle gaps, closing sample 3500 being the maximum → peak=3500, level_num=12; next window's first sample 2000 is not merged into the previous peak (next window peak independent).
- Back-to-back: sample_valid held high for 12 cycles with WINDOW=4 → exactly three level_valid pulses, spaced 4 clocks apart, each reflecting only its own 4 samples.
